// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller with mask, edge/level mode and fixed priority
//   clk/reset : clock, asynchronous active-high reset
//   Addr/WE/Din/Dout : word-addressed register port (Addr[3:2]: MASK, MODE, PEND, STAT/EOI)
//   irq_in : raw (possibly asynchronous) requests, index 0 highest priority
//   HWInt  : one-hot in-service source, zero when idle
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [29:0]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] irq_in,
    output logic [N_SRC-1:0] HWInt
);
    typedef enum logic {IDLE, SERVICE} state_t;
    state_t state_q, state_d;
    logic [N_SRC-1:0] s1_q, s2_q, s3_q;
    logic [N_SRC-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, hw_q, hw_d;
    logic [N_SRC-1:0] active, claim, clr, rise;
    logic [2:0] id_q, id_d, idx;
    logic wr_mask, wr_mode, wr_pend, wr_eoi;
    logic unused_ok;
    assign unused_ok = ^{Addr[29:4], Addr[1:0], Din[31:N_SRC]};
    assign wr_mask = WE && Addr[3:2] == 2'd0;
    assign wr_mode = WE && Addr[3:2] == 2'd1;
    assign wr_pend = WE && Addr[3:2] == 2'd2;
    assign wr_eoi  = WE && Addr[3:2] == 2'd3;
    assign active = pend_q & mask_q;
    assign rise = s2_q & ~s3_q;
    assign HWInt = hw_q;
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (active[i]) idx = 3'(i);
    end
    always_comb begin
        state_d = state_q;
        id_d = id_q;
        hw_d = hw_q;
        claim = '0;
        if (state_q == IDLE) begin
            if (|active) begin
                // isolate lowest set bit = highest-priority active source
                claim = active & (~active + 1'b1);
                state_d = SERVICE;
                id_d = idx;
                hw_d = claim;
            end
        end else if (wr_eoi) begin
            state_d = IDLE;
            hw_d = '0;
        end
    end
    always_comb begin
        mask_d = wr_mask ? Din[N_SRC-1:0] : mask_q;
        mode_d = wr_mode ? Din[N_SRC-1:0] : mode_q;
        clr = (wr_pend ? Din[N_SRC-1:0] : '0) | claim;
        // level bits follow s2 (a level->edge switch clears except for a fresh edge);
        // edge bits set on rise, which wins over W1C/claim clears
        pend_d = (~mode_q & ((mode_d & rise) | (~mode_d & s2_q)))
               | (mode_q & (rise | (pend_q & ~clr)));
    end
    always_comb
        Dout = Addr[3:2] == 2'd0 ? 32'(mask_q) :
               Addr[3:2] == 2'd1 ? 32'(mode_q) :
               Addr[3:2] == 2'd2 ? 32'(pend_q) :
               {state_q == SERVICE, 28'b0, id_q};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
            hw_q <= '0;
            id_q <= '0;
        end else begin
            state_q <= state_d;
            s1_q <= irq_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            mask_q <= mask_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            hw_q <= hw_d;
            id_q <= id_d;
        end
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Programmable interrupt controller between the peripheral IRQ lines (TC0, TC1, external `interrupt`) and the CPU `HWInt` inputs. It sits on the Bridge device bus as a word-addressed register device. It synchronizes and latches requests, applies per-source mask and edge/level mode, and picks the highest-priority pending source. It then presents that source to the CPU as a one-hot `HWInt` until the handler writes end-of-interrupt (EOI).

## Interface
- `N_SRC`, default 6: number of request sources, 1..8; lower index has higher priority.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `Addr` input 30: word address `DEV_Addr[31:2]`; only `Addr[3:2]` is decoded. The Bridge qualifies the device select through `WE`.
- `WE` input 1: register write strobe from Bridge, one cycle per store.
- `Din` input 32: write data.
- `Dout` output 32: read data, combinational from `Addr[3:2]` and the current registers.
- `irq_in` input N_SRC: raw requests; may be asynchronous, e.g. the external pin.
- `HWInt` output N_SRC: registered one-hot of the in-service source; all zero when idle.

## Operation
- Registers, selected by `Addr[3:2]`; bits at `N_SRC` and above read 0 and ignore writes:
  - 0 MASK (RW): 1 = source enabled.
  - 1 MODE (RW): 1 = rising-edge, 0 = level.
  - 2 PEND (R/W1C): pending bits. Writing 1 clears an edge-mode bit; writes to level-mode bits are ignored.
  - 3 STAT/EOI: read gives `{busy, 28'b0, id[2:0]}`. Any write is EOI.
- Synchronizer: each `irq_in` bit passes through two flops (`s1`, `s2`), plus a history flop `s3`.
- Pending update, per bit:
  - Level mode: `PEND <= s2`.
  - Edge mode: set on `s2 & ~s3`, cleared by W1C or by claim.
  - Set wins over clear in the same cycle.
- MODE change:
  - Edge→level: PEND reloads from `s2` on the next cycle.
  - Level→edge: PEND clears in the write cycle.
- `active = PEND & MASK`.
- FSM:
  - IDLE: if `active != 0`, claim the lowest-index active bit. Latch `id`, set `HWInt` one-hot, and clear that PEND bit if it is edge-mode. Go to SERVICE.
  - SERVICE: `HWInt` and `id` are held regardless of later MASK or PEND changes; no nesting or preemption. An EOI write goes to IDLE and `HWInt` becomes 0.
- EOI write while IDLE is ignored.
- A level source still high after EOI is re-claimed from IDLE.
- Edges arriving during SERVICE, including on the in-service source, set PEND and are claimed later. Repeated edges on the same bit coalesce into one pending request.

## Timing
- Reset values: MASK 0, MODE 0, PEND 0, `s1`/`s2`/`s3` 0, state IDLE, `id` 0, `HWInt` 0, `Dout` = register content at offset `Addr[3:2]` (all 0).
- Request latency: `irq_in` sampled high at edge k gives `s2` high after edge k+1. PEND sets after edge k+2. `HWInt` asserts after edge k+3.
- EOI written at edge j: `HWInt` = 0 after edge j. The earliest next claim is after edge j+1, so at least one idle cycle separates services.
- Register writes take effect at the write edge; `Dout` reflects the new value in the following cycle.
- A claim and a W1C of the same bit in the same cycle: the claim proceeds, and the bit ends cleared unless a new edge sets it.
- Reset mid-service: `HWInt` drops asynchronously; pending requests are lost.

## Test plan
- Reset, then read all four offsets → all 0, `HWInt` = 0. Assert reset during SERVICE → `HWInt` = 0 immediately.
- MASK = 0x3F, MODE = 0. Raise `irq_in[1]` at edge k → `HWInt` = 6'b000010 after edge k+3, STAT reads 0x80000001. Write EOI with `irq_in[1]` still high → `HWInt` = 0 for one cycle, then reasserts 0x02.
- MODE = 0x3F. Pulse `irq_in[0]` and `irq_in[2]` in the same cycle → `HWInt` = 0x01 first and PEND = 0x04. EOI → `HWInt` = 0x04 after two edges, PEND = 0.
- MASK = 0x04, edge mode. Pulse `irq_in[0]` → no `HWInt`, PEND = 0x01. Write PEND 0x01 → PEND = 0. Write W1C in the same cycle as a new detected edge → PEND stays 0x01.
- In SERVICE on source 3, edge mode: pulse `irq_in[3]` three times → `HWInt` held 0x08, PEND = 0x08. EOI → exactly one further service of source 3, then idle.
- Clear MASK bit 2 during SERVICE on source 2 → `HWInt` stays 0x04 until EOI. EOI write while IDLE → no state change.
